// File: rtl/clock_tamer_pkg.sv
// Shared definitions for the GPS clock counter SPI controller: field widths,
// control-bit values and the FSM encodings.
package clock_tamer_pkg;
    localparam int COUNTER_BITS_DEF = 27;
    localparam int COMPARE_BITS_DEF = 28;

    localparam logic CTL_READ   = 1'b1;
    localparam logic CTL_UPDATE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_TERM
    } state_t;

    // TERM is three H-cycle phases: frame enable high, cleanup pulse high, pulse low.
    typedef enum logic [1:0] {
        TERM_SEN,
        TERM_HI,
        TERM_LO
    } term_ph_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_READ,
        FR_UPDATE
    } frame_t;
endpackage

// File: rtl/spi_phase_timer.sv
// H-cycle down-counter shared by every timed FSM state; expire is high on the
// last cycle of a phase that began with start.
module spi_phase_timer #(
    parameter int HALF_PERIOD = 8
) (
    input  logic clk,
    input  logic start,
    output logic expire
);
    localparam int W = $clog2(HALF_PERIOD);
    localparam logic [W-1:0] LOAD = W'(HALF_PERIOD - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (start) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = (cnt_q == '0);
endmodule

// File: rtl/clock_counter_spi_ctrl.sv
// Sequences periodic count reads and host compare-value updates onto the
// single SPI link of the CPLD GPS clock counter.
module clock_counter_spi_ctrl
    import clock_tamer_pkg::*;
#(
    parameter int COUNTER_BITS = COUNTER_BITS_DEF,
    parameter int COMPARE_BITS = COMPARE_BITS_DEF,
    parameter int HALF_PERIOD  = 8,
    parameter int POLL_CYCLES  = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    poll_en,
    input  logic                    upd_req,
    input  logic [COMPARE_BITS-1:0] upd_value,
    output logic                    upd_ack,
    output logic                    rd_done,
    output logic                    rd_fresh,
    output logic [COUNTER_BITS-1:0] count_value,
    output logic                    busy,
    output logic                    spi_clk,
    output logic                    spi_sen,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);
    localparam int RXW  = COUNTER_BITS + 1;
    localparam int TXW  = COMPARE_BITS + 1;
    localparam int MAXP = (RXW > TXW) ? RXW : TXW;
    localparam int BW   = $clog2(MAXP + 1);
    localparam int PW   = $clog2(POLL_CYCLES);

    localparam logic [BW-1:0]  RD_PULSES = BW'(RXW);
    localparam logic [BW-1:0]  UP_PULSES = BW'(TXW);
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TXW-1:0] TX_READ   = {CTL_READ, {COMPARE_BITS{1'b0}}};

    state_t                  state_q, state_d;
    term_ph_t                ph_q, ph_d;
    frame_t                  frame_q, frame_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [TXW-1:0]          tx_q, tx_d;
    logic [RXW-1:0]          rx_q, rx_d;
    logic [PW-1:0]           poll_cnt_q, poll_cnt_d;
    logic                    poll_pend_q, poll_pend_d;
    logic                    fresh_q, fresh_d;
    logic [COUNTER_BITS-1:0] count_q, count_d;
    logic                    poll_hit, tmr_start, tmr_expire, last_term;
    logic [BW-1:0]           pulses_need;

    spi_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk    (clk),
        .start  (tmr_start | reset),
        .expire (tmr_expire)
    );

    assign poll_hit    = poll_en && (poll_cnt_q == POLL_LAST);
    assign pulses_need = (frame_q == FR_READ) ? RD_PULSES : UP_PULSES;

    always_comb begin
        poll_cnt_d = '0;
        if (poll_en && !poll_hit) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        frame_d     = frame_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        fresh_d     = fresh_q;
        count_d     = count_q;
        poll_pend_d = poll_pend_q | poll_hit;
        tmr_start   = 1'b0;
        last_term   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (upd_req) begin
                    state_d   = ST_SETUP;
                    frame_d   = FR_UPDATE;
                    tx_d      = {CTL_UPDATE, upd_value};
                    bit_d     = '0;
                    tmr_start = 1'b1;
                end else if (poll_pend_q) begin
                    state_d     = ST_SETUP;
                    frame_d     = FR_READ;
                    tx_d        = TX_READ;
                    bit_d       = '0;
                    tmr_start   = 1'b1;
                    poll_pend_d = poll_hit;
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    state_d   = ST_CLK_HI;
                    rx_d      = {rx_q[RXW-2:0], spi_miso};
                    tmr_start = 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (tmr_expire) begin
                    state_d   = ST_CLK_LO;
                    tx_d      = {tx_q[TXW-2:0], 1'b0};
                    bit_d     = bit_q + 1'b1;
                    tmr_start = 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (tmr_expire) begin
                    tmr_start = 1'b1;
                    if (bit_q == pulses_need) begin
                        state_d = ST_TERM;
                        ph_d    = TERM_SEN;
                        // Results are latched at frame end so they are stable through TERM.
                        if (frame_q == FR_READ) begin
                            fresh_d = rx_q[RXW-1];
                            if (rx_q[RXW-1]) begin
                                count_d = rx_q[COUNTER_BITS-1:0];
                            end
                        end
                    end else begin
                        state_d = ST_CLK_HI;
                        rx_d    = {rx_q[RXW-2:0], spi_miso};
                    end
                end
            end
            ST_TERM: begin
                if (tmr_expire) begin
                    tmr_start = 1'b1;
                    case (ph_q)
                        TERM_SEN: ph_d = TERM_HI;
                        TERM_HI:  ph_d = TERM_LO;
                        default: begin
                            state_d   = ST_IDLE;
                            ph_d      = TERM_SEN;
                            frame_d   = FR_NONE;
                            last_term = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = ST_TERM;
        endcase
    end

    // Reset forces the cleanup sequence so a frame aborted mid-transfer is closed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_TERM;
            ph_q        <= TERM_SEN;
            frame_q     <= FR_NONE;
            bit_q       <= '0;
            tx_q        <= '0;
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
            fresh_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            poll_cnt_q  <= poll_cnt_d;
            poll_pend_q <= poll_pend_d;
            fresh_q     <= fresh_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_q <= rx_d;
    end

    assign rd_done     = last_term && (frame_q == FR_READ) && !reset;
    assign upd_ack     = last_term && (frame_q == FR_UPDATE) && !reset;
    assign rd_fresh    = fresh_q;
    assign count_value = count_q;
    assign busy        = (state_q != ST_IDLE);
    assign spi_sen     = !((state_q == ST_SETUP) || (state_q == ST_CLK_HI) || (state_q == ST_CLK_LO));
    assign spi_clk     = (state_q == ST_CLK_HI) || ((state_q == ST_TERM) && (ph_q == TERM_HI));
    assign spi_mosi    = tx_q[TXW-1];
endmodule
